// File: rtl/conv_layer_core.sv
// Direct 2-D convolution engine: one tap per cycle, one signed MAC lane per input channel,
// bias add and saturating requantisation, one int8 write per output pixel and channel.
module conv_layer_core #(
    parameter int IMG_DIM    = 32,
    parameter int OUT_DIM    = 32,
    parameter int IN_CH      = 3,
    parameter int OUT_CH     = 32,
    parameter int KERNEL     = 5,
    parameter int STRIDE     = 1,
    parameter int PADDING    = 2,
    parameter int BIAS_SHIFT = 6,
    parameter int OUT_SHIFT  = 9,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [IN_CH*ADDR_W-1:0] img_addr,
    input  logic [IN_CH*8-1:0]      img_data,
    output logic [IN_CH*ADDR_W-1:0] wgt_addr,
    input  logic [IN_CH*8-1:0]      wgt_data,
    output logic [7:0]              bias_addr,
    input  logic [7:0]              bias_data,
    output logic                    out_we,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [7:0]              out_data
);

    localparam int CW = 16;
    localparam logic [CW-1:0] K_LAST = CW'(KERNEL - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OUT_DIM - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OUT_CH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] i_c, j_c, k_c, n_c, m_c;
    logic          run, m_end, n_end, k_end, j_end, i_end;
    logic          tap_first, tap_last, final_tap;

    logic signed [31:0] in_row, in_col, pix_idx, wgt_idx;
    logic               tap_ok;

    logic              v1, first1, last1, ok1, fin1;
    logic [7:0]        i1;
    logic [ADDR_W-1:0] oaddr1, oaddr2, oaddr3;
    logic              v2, fin2, v3, fin3;

    logic signed [17:0] prod [IN_CH];
    logic signed [21:0] acc  [IN_CH];
    logic signed [23:0] lane_sum, bias_ext, sum_q, shifted;

    assign run       = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign m_end     = (m_c == K_LAST);
    assign n_end     = (n_c == K_LAST);
    assign k_end     = (k_c == O_LAST);
    assign j_end     = (j_c == O_LAST);
    assign i_end     = (i_c == C_LAST);
    assign tap_first = (n_c == '0) && (m_c == '0);
    assign tap_last  = n_end && m_end;
    assign final_tap = run && tap_last && k_end && j_end && i_end;

    // Loop sequencer: m innermost, i outermost; DRAIN covers the three pipeline stages after the last tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            i_c   <= '0;
            j_c   <= '0;
            k_c   <= '0;
            n_c   <= '0;
            m_c   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        i_c   <= '0;
                        j_c   <= '0;
                        k_c   <= '0;
                        n_c   <= '0;
                        m_c   <= '0;
                    end
                end
                S_RUN: begin
                    if (final_tap) state <= S_DRAIN;
                    if (!m_end) begin
                        m_c <= m_c + 1'b1;
                    end else begin
                        m_c <= '0;
                        if (!n_end) begin
                            n_c <= n_c + 1'b1;
                        end else begin
                            n_c <= '0;
                            if (!k_end) begin
                                k_c <= k_c + 1'b1;
                            end else begin
                                k_c <= '0;
                                if (!j_end) begin
                                    j_c <= j_c + 1'b1;
                                end else begin
                                    j_c <= '0;
                                    i_c <= i_end ? '0 : i_c + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_row  = int'(j_c) * STRIDE + int'(n_c) - PADDING;
        in_col  = int'(k_c) * STRIDE + int'(m_c) - PADDING;
        tap_ok  = (in_row >= 0) && (in_row < IMG_DIM) && (in_col >= 0) && (in_col < IMG_DIM);
        pix_idx = in_row * IMG_DIM + in_col;
        wgt_idx = (int'(i_c) * KERNEL + int'(n_c)) * KERNEL + int'(m_c);
    end

    // Padding taps still issue wrapped addresses; only the MAC enable masks them.
    always_comb begin
        img_addr = '0;
        wgt_addr = '0;
        if (run) begin
            for (int l = 0; l < IN_CH; l++) begin
                img_addr[l*ADDR_W +: ADDR_W] = ADDR_W'(pix_idx * IN_CH + l);
                wgt_addr[l*ADDR_W +: ADDR_W] = ADDR_W'(wgt_idx * IN_CH + l);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            ok1    <= 1'b0;
            fin1   <= 1'b0;
            i1     <= '0;
            oaddr1 <= '0;
            v2     <= 1'b0;
            fin2   <= 1'b0;
            oaddr2 <= '0;
            v3     <= 1'b0;
            fin3   <= 1'b0;
            oaddr3 <= '0;
            sum_q  <= '0;
        end else begin
            v1     <= run;
            first1 <= tap_first;
            last1  <= tap_last;
            ok1    <= tap_ok;
            fin1   <= final_tap;
            i1     <= i_c[7:0];
            oaddr1 <= ADDR_W'((int'(j_c) * OUT_DIM + int'(k_c)) * OUT_CH + int'(i_c));
            v2     <= v1 && last1;
            fin2   <= v1 && fin1;
            oaddr2 <= oaddr1;
            v3     <= v2;
            fin3   <= v2 && fin2;
            oaddr3 <= oaddr2;
            if (v2) sum_q <= lane_sum + bias_ext;
        end
    end

    always_comb begin
        for (int l = 0; l < IN_CH; l++) begin
            prod[l] = $signed({wgt_data[l*8+7], wgt_data[l*8 +: 8]}) * $signed({1'b0, img_data[l*8 +: 8]});
        end
    end

    // The first tap of a pixel reloads the lanes, so the next pixel overlaps the previous drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < IN_CH; l++) acc[l] <= '0;
        end else if (v1) begin
            for (int l = 0; l < IN_CH; l++) begin
                if (first1) begin
                    acc[l] <= ok1 ? $signed({{4{prod[l][17]}}, prod[l]}) : '0;
                end else if (ok1) begin
                    acc[l] <= acc[l] + $signed({{4{prod[l][17]}}, prod[l]});
                end
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < IN_CH; l++) begin
            lane_sum = lane_sum + $signed({{2{acc[l][21]}}, acc[l]});
        end
        bias_ext = $signed({{16{bias_data[7]}}, bias_data}) <<< BIAS_SHIFT;
    end

    always_comb begin
        shifted = sum_q >>> OUT_SHIFT;
        if (shifted > 24'sd127) begin
            out_data = 8'h7F;
        end else if (shifted < -24'sd128) begin
            out_data = 8'h80;
        end else begin
            out_data = shifted[7:0];
        end
    end

    assign bias_addr = v1 ? i1 : '0;
    assign out_we    = v3;
    assign out_addr  = oaddr3;
    assign done      = v3 && fin3;

endmodule

// File: tb/tb_conv_layer_core.sv
// Scoreboard bench for conv_layer_core on a reduced 8x8x2 layer with synchronous memory models.
module tb_conv_layer_core;

    localparam int IMG   = 8;
    localparam int ODIM  = 8;
    localparam int INC   = 3;
    localparam int OCH   = 2;
    localparam int K     = 5;
    localparam int STR   = 1;
    localparam int PAD   = 2;
    localparam int BSH   = 6;
    localparam int OSH   = 9;
    localparam int AW    = 16;
    localparam int TAPS  = OCH * ODIM * ODIM * K * K;
    localparam int NPIX  = OCH * ODIM * ODIM;
    localparam int IMG_N = IMG * IMG * INC;
    localparam int WGT_N = OCH * K * K * INC;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset, start, busy, done, out_we;
    logic [INC*AW-1:0] img_addr, wgt_addr;
    logic [INC*8-1:0]  img_data, wgt_data;
    logic [7:0]        bias_addr, bias_data, out_data;
    logic [AW-1:0]     out_addr;

    logic [7:0] img_mem  [IMG_N];
    logic [7:0] wgt_mem  [WGT_N];
    logic [7:0] bias_mem [OCH];
    logic [7:0] out_cap  [NPIX];
    exp_t       sb_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int prev_we = 0;
    bit have_prev = 1'b0;
    bit busy_prev = 1'b0;

    conv_layer_core #(
        .IMG_DIM(IMG), .OUT_DIM(ODIM), .IN_CH(INC), .OUT_CH(OCH), .KERNEL(K),
        .STRIDE(STR), .PADDING(PAD), .BIAS_SHIFT(BSH), .OUT_SHIFT(OSH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .img_addr(img_addr), .img_data(img_data),
        .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias_addr(bias_addr), .bias_data(bias_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int l = 0; l < INC; l++) begin
            img_data[l*8 +: 8] <= (int'(img_addr[l*AW +: AW]) < IMG_N) ? img_mem[int'(img_addr[l*AW +: AW])] : 8'h00;
            wgt_data[l*8 +: 8] <= (int'(wgt_addr[l*AW +: AW]) < WGT_N) ? wgt_mem[int'(wgt_addr[l*AW +: AW])] : 8'h00;
        end
        bias_data <= (int'(bias_addr) < OCH) ? bias_mem[int'(bias_addr)] : 8'h00;
    end

    function automatic logic [7:0] model(input int i, input int j, input int k);
        int s, r, c, res;
        s = 0;
        for (int n = 0; n < K; n++) begin
            for (int m = 0; m < K; m++) begin
                r = j * STR + n - PAD;
                c = k * STR + m - PAD;
                if (r >= 0 && r < IMG && c >= 0 && c < IMG) begin
                    for (int l = 0; l < INC; l++) begin
                        s += int'($signed(wgt_mem[((i * K + n) * K + m) * INC + l])) * int'(img_mem[(r * IMG + c) * INC + l]);
                    end
                end
            end
        end
        s += int'($signed(bias_mem[i])) * (1 << BSH);
        res = s >>> OSH;
        if (res > 127) res = 127;
        if (res < -128) res = -128;
        return 8'(res);
    endfunction

    task automatic fill_image(input bit rnd, input logic [7:0] v);
        for (int a = 0; a < IMG_N; a++) img_mem[a] = rnd ? 8'($urandom) : v;
    endtask

    task automatic fill_weights(input bit rnd, input logic [7:0] v);
        for (int a = 0; a < WGT_N; a++) wgt_mem[a] = rnd ? 8'($urandom) : v;
    endtask

    // Runs alongside the stimulus: pops one expected write per out_we and checks write timing.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && !busy_prev) begin
                start_cyc = cyc - 1;
                have_prev = 1'b0;
            end
            busy_prev = (busy === 1'b1);
            if (out_we === 1'b1) begin
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("[TB] FAIL unexpected_write: observed write to %0d, expected none", out_addr);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    assert (out_addr === e.addr) else begin
                        n_err++;
                        $error("[TB] FAIL out_addr: observed %0d expected %0d", out_addr, e.addr);
                    end
                    n_cmp++;
                    assert (out_data === e.data) else begin
                        n_err++;
                        $error("[TB] FAIL out_data@%0d: observed %0d expected %0d", e.addr, $signed(out_data), $signed(e.data));
                    end
                end
                if (int'(out_addr) < NPIX) out_cap[int'(out_addr)] = out_data;
                n_cmp++;
                if (have_prev) begin
                    assert (cyc - prev_we === K * K) else begin
                        n_err++;
                        $error("[TB] FAIL write_gap: observed %0d expected %0d", cyc - prev_we, K * K);
                    end
                end else begin
                    assert (cyc - start_cyc === K * K + 3) else begin
                        n_err++;
                        $error("[TB] FAIL first_write_latency: observed %0d expected %0d", cyc - start_cyc, K * K + 3);
                    end
                end
                have_prev = 1'b1;
                prev_we = cyc;
            end
            if (done === 1'b1) begin
                n_cmp++;
                assert (out_we === 1'b1 && sb_q.size() == 0) else begin
                    n_err++;
                    $error("[TB] FAIL done_alignment: observed we=%b pending=%0d expected we=1 pending=0", out_we, sb_q.size());
                end
                n_cmp++;
                assert (cyc - start_cyc === TAPS + 3) else begin
                    n_err++;
                    $error("[TB] FAIL run_length: observed %0d expected %0d", cyc - start_cyc, TAPS + 3);
                end
            end
        end
    endtask

    task automatic apply_stimulus();
        int a0;
        for (int a = 0; a < NPIX; a++) out_cap[a] = 'x;
        for (int i = 0; i < OCH; i++)
            for (int j = 0; j < ODIM; j++)
                for (int k = 0; k < ODIM; k++)
                    sb_q.push_back({AW'((j * ODIM + k) * OCH + i), model(i, j, k)});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a0 = ((0 * STR - PAD) * IMG + (0 * STR - PAD)) * INC;
        n_cmp++;
        assert (busy === 1'b1) else begin
            n_err++;
            $error("[TB] FAIL busy_after_start: observed %b expected 1", busy);
        end
        n_cmp++;
        assert (img_addr[0 +: AW] === AW'(a0) && img_addr[2*AW +: AW] === AW'(a0 + 2)) else begin
            n_err++;
            $error("[TB] FAIL first_img_addr: observed %h/%h expected %h/%h", img_addr[0 +: AW], img_addr[2*AW +: AW], AW'(a0), AW'(a0 + 2));
        end
        n_cmp++;
        assert (wgt_addr[0 +: AW] === '0 && wgt_addr[2*AW +: AW] === AW'(2)) else begin
            n_err++;
            $error("[TB] FAIL first_wgt_addr: observed %h/%h expected 0/2", wgt_addr[0 +: AW], wgt_addr[2*AW +: AW]);
        end
    endtask

    task automatic check_output();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < TAPS + 100);
        n_cmp++;
        assert (done === 1'b1) else begin
            n_err++;
            $error("[TB] FAIL done_timeout: observed no done within %0d cycles", TAPS + 100);
        end
        @(negedge clk);
        n_cmp++;
        assert (busy === 1'b0) else begin
            n_err++;
            $error("[TB] FAIL busy_after_done: observed %b expected 0", busy);
        end
    endtask

    task automatic check_cap(input string tag, input int j, input int k, input int i, input logic [7:0] v);
        n_cmp++;
        assert (out_cap[(j * ODIM + k) * OCH + i] === v) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(out_cap[(j * ODIM + k) * OCH + i]), $signed(v));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_image(1'b0, 8'd0);
        fill_weights(1'b0, 8'd0);
        bias_mem[0] = 8'd0;
        bias_mem[1] = 8'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            n_cmp++;
            assert ({busy, done, out_we, img_addr, wgt_addr, bias_addr, out_addr, out_data} === '0) else begin
                n_err++;
                $error("[TB] FAIL idle_outputs: observed busy=%b done=%b we=%b img=%h wgt=%h bias=%h oaddr=%h odata=%h expected all 0",
                       busy, done, out_we, img_addr, wgt_addr, bias_addr, out_addr, out_data);
            end
        end

        // All-ones kernel over a saturated image, with a start pulse mid-run that must be ignored.
        fill_image(1'b0, 8'd255);
        fill_weights(1'b0, 8'd1);
        apply_stimulus();
        repeat (700) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output();
        for (int i = 0; i < OCH; i++) begin
            check_cap("ones_center", 4, 4, i, 8'd37);
            check_cap("ones_corner", 0, 0, i, 8'd13);
            check_cap("ones_edge", 0, 4, i, 8'd22);
            check_cap("ones_far_corner", 7, 7, i, 8'd13);
        end

        fill_image(1'b1, 8'd0);
        fill_weights(1'b0, 8'd0);
        bias_mem[0] = 8'd64;
        bias_mem[1] = 8'h80;
        apply_stimulus();
        check_output();
        for (int j = 0; j < ODIM; j++)
            for (int k = 0; k < ODIM; k++) begin
                check_cap("bias_only_ch0", j, k, 0, 8'd8);
                check_cap("bias_only_ch1", j, k, 1, 8'hF0);
            end

        fill_image(1'b0, 8'd255);
        fill_weights(1'b0, 8'd127);
        bias_mem[0] = 8'd0;
        bias_mem[1] = 8'd0;
        apply_stimulus();
        check_output();
        check_cap("sat_pos_center", 4, 4, 0, 8'h7F);
        check_cap("sat_pos_center", 4, 4, 1, 8'h7F);

        fill_weights(1'b0, 8'h80);
        apply_stimulus();
        check_output();
        check_cap("sat_neg_center", 4, 4, 0, 8'h80);
        check_cap("sat_neg_center", 4, 4, 1, 8'h80);

        fill_image(1'b1, 8'd0);
        fill_weights(1'b1, 8'd0);
        bias_mem[0] = 8'($urandom);
        bias_mem[1] = 8'($urandom);
        apply_stimulus();
        check_output();

        // Abort a run with reset, then confirm a fresh run restarts cleanly.
        apply_stimulus();
        repeat (500) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        assert (busy === 1'b0 && out_we === 1'b0) else begin
            n_err++;
            $error("[TB] FAIL reset_abort: observed busy=%b we=%b expected 0/0", busy, out_we);
        end
        reset = 1'b0;
        sb_q.delete();
        repeat (40) @(negedge clk);
        fill_image(1'b1, 8'd0);
        fill_weights(1'b1, 8'd0);
        bias_mem[0] = 8'($urandom);
        bias_mem[1] = 8'($urandom);
        apply_stimulus();
        check_output();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
